// File: rtl/axi_reg_bridge.sv
// axi_reg_bridge
//   Single-outstanding bridge from an AXI4 slave port to a 32-bit REG_BUS
//   master. Each legal AXI access (len==0, size<=2) becomes exactly one
//   REG_BUS transaction. Illegal accesses are answered with SLVERR without
//   touching the register bus; illegal writes still drain every W beat.
//
//   Ports
//     clk_i, rst_i               clock, synchronous active-high reset
//     aw_* / w_* / b_*           AXI write address, data and response channels
//     ar_* / r_*                 AXI read address and data channels
//     reg_addr_o .. reg_write_o  REG_BUS request fields
//     reg_valid_o / reg_ready_i  REG_BUS handshake
//     reg_rdata_i / reg_error_i  REG_BUS response, valid with reg_ready_i
module axi_reg_bridge #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 7,
  parameter int unsigned RegAw     = 8,
  parameter int unsigned RegDw     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [RegAw-1:0]       reg_addr_o,
  output logic [RegDw-1:0]       reg_wdata_o,
  output logic [RegDw/8-1:0]     reg_wstrb_o,
  output logic                   reg_write_o,
  output logic                   reg_valid_o,
  input  logic                   reg_ready_i,
  input  logic [RegDw-1:0]       reg_rdata_i,
  input  logic                   reg_error_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WREQ  = 3'd2,
    ST_WRESP = 3'd3,
    ST_RREQ  = 3'd4,
    ST_RRESP = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 wr_prio_q, wr_prio_d;   // 1: write wins a tie
  logic [IdWidth-1:0]   id_q, id_d;
  logic                 legal_q, legal_d;
  logic                 lane_hi_q, lane_hi_d;   // captured addr[2]
  logic [7:0]           beats_left_q, beats_left_d;
  logic [RegAw-1:0]     reg_addr_q, reg_addr_d;
  logic [RegDw-1:0]     reg_wdata_q, reg_wdata_d;
  logic [RegDw/8-1:0]   reg_wstrb_q, reg_wstrb_d;
  logic                 reg_write_q, reg_write_d;
  logic                 reg_valid_q, reg_valid_d;
  logic                 b_valid_q, b_valid_d;
  logic [1:0]           b_resp_q, b_resp_d;
  logic                 r_valid_q, r_valid_d;
  logic [DataWidth-1:0] r_data_q, r_data_d;
  logic [1:0]           r_resp_q, r_resp_d;
  logic                 r_last_q, r_last_d;

  logic grant_w, grant_r, idle_s;
  logic unused_bits;

  // Address bits outside the register window and the byte offset are ignored.
  assign unused_bits = ^{aw_addr_i[AddrWidth-1:RegAw], aw_addr_i[1:0],
                         ar_addr_i[AddrWidth-1:RegAw], ar_addr_i[1:0]};

  // Arbitration and AXI ready decode; only the AXI inputs and state feed these.
  always_comb begin
    idle_s     = (state_q == ST_IDLE);
    grant_w    = aw_valid_i & (~ar_valid_i | wr_prio_q);
    grant_r    = ar_valid_i & (~aw_valid_i | ~wr_prio_q);
    aw_ready_o = idle_s & grant_w;
    ar_ready_o = idle_s & grant_r;
    w_ready_o  = (state_q == ST_WDATA);
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    wr_prio_d    = wr_prio_q;
    id_d         = id_q;
    legal_d      = legal_q;
    lane_hi_d    = lane_hi_q;
    beats_left_d = beats_left_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wstrb_d  = reg_wstrb_q;
    reg_write_d  = reg_write_q;
    reg_valid_d  = reg_valid_q;
    b_valid_d    = b_valid_q;
    b_resp_d     = b_resp_q;
    r_valid_d    = r_valid_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    r_last_d     = r_last_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_w) begin
          // The pointer only moves when a tie was actually decided.
          if (ar_valid_i) begin
            wr_prio_d = 1'b0;
          end else begin
            wr_prio_d = wr_prio_q;
          end
          id_d       = aw_id_i;
          reg_addr_d = {aw_addr_i[RegAw-1:2], 2'b00};
          legal_d    = (aw_len_i == 8'd0) && (aw_size_i <= 3'd2);
          lane_hi_d  = aw_addr_i[2];
          state_d    = ST_WDATA;
        end else if (grant_r) begin
          if (aw_valid_i) begin
            wr_prio_d = 1'b1;
          end else begin
            wr_prio_d = wr_prio_q;
          end
          id_d       = ar_id_i;
          reg_addr_d = {ar_addr_i[RegAw-1:2], 2'b00};
          legal_d    = (ar_len_i == 8'd0) && (ar_size_i <= 3'd2);
          if ((ar_len_i == 8'd0) && (ar_size_i <= 3'd2)) begin
            reg_valid_d = 1'b1;
            reg_write_d = 1'b0;
            state_d     = ST_RREQ;
          end else begin
            // Error burst: len+1 beats of zero data, no register access.
            r_valid_d    = 1'b1;
            r_data_d     = {DataWidth{1'b0}};
            r_resp_d     = RespSlverr;
            r_last_d     = (ar_len_i == 8'd0);
            beats_left_d = ar_len_i;
            state_d      = ST_RRESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WDATA: begin
        if (w_valid_i) begin
          if (legal_q) begin
            if (lane_hi_q) begin
              reg_wdata_d = w_data_i[2*RegDw-1:RegDw];
              reg_wstrb_d = w_strb_i[2*(RegDw/8)-1:RegDw/8];
            end else begin
              reg_wdata_d = w_data_i[RegDw-1:0];
              reg_wstrb_d = w_strb_i[RegDw/8-1:0];
            end
          end else begin
            reg_wdata_d = reg_wdata_q;
            reg_wstrb_d = reg_wstrb_q;
          end
          if (w_last_i) begin
            if (legal_q) begin
              reg_valid_d = 1'b1;
              reg_write_d = 1'b1;
              state_d     = ST_WREQ;
            end else begin
              b_valid_d = 1'b1;
              b_resp_d  = RespSlverr;
              state_d   = ST_WRESP;
            end
          end else begin
            state_d = ST_WDATA;
          end
        end else begin
          state_d = ST_WDATA;
        end
      end

      ST_WREQ: begin
        if (reg_ready_i) begin
          reg_valid_d = 1'b0;
          b_valid_d   = 1'b1;
          b_resp_d    = reg_error_i ? RespSlverr : RespOkay;
          state_d     = ST_WRESP;
        end else begin
          state_d = ST_WREQ;
        end
      end

      ST_WRESP: begin
        if (b_ready_i) begin
          b_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WRESP;
        end
      end

      ST_RREQ: begin
        if (reg_ready_i) begin
          reg_valid_d = 1'b0;
          r_valid_d   = 1'b1;
          r_data_d    = {reg_rdata_i, reg_rdata_i};
          r_resp_d    = reg_error_i ? RespSlverr : RespOkay;
          r_last_d    = 1'b1;
          state_d     = ST_RRESP;
        end else begin
          state_d = ST_RREQ;
        end
      end

      ST_RRESP: begin
        if (r_ready_i) begin
          if (r_last_q) begin
            r_valid_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            beats_left_d = beats_left_q - 8'd1;
            r_last_d     = (beats_left_q == 8'd1);
            state_d      = ST_RRESP;
          end
        end else begin
          state_d = ST_RRESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_prio_q    <= 1'b1;
      id_q         <= {IdWidth{1'b0}};
      legal_q      <= 1'b0;
      lane_hi_q    <= 1'b0;
      beats_left_q <= 8'd0;
      reg_addr_q   <= {RegAw{1'b0}};
      reg_wdata_q  <= {RegDw{1'b0}};
      reg_wstrb_q  <= {(RegDw/8){1'b0}};
      reg_write_q  <= 1'b0;
      reg_valid_q  <= 1'b0;
      b_valid_q    <= 1'b0;
      b_resp_q     <= 2'b00;
      r_valid_q    <= 1'b0;
      r_data_q     <= {DataWidth{1'b0}};
      r_resp_q     <= 2'b00;
      r_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_prio_q    <= wr_prio_d;
      id_q         <= id_d;
      legal_q      <= legal_d;
      lane_hi_q    <= lane_hi_d;
      beats_left_q <= beats_left_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wstrb_q  <= reg_wstrb_d;
      reg_write_q  <= reg_write_d;
      reg_valid_q  <= reg_valid_d;
      b_valid_q    <= b_valid_d;
      b_resp_q     <= b_resp_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_resp_q     <= r_resp_d;
      r_last_q     <= r_last_d;
    end
  end

  assign b_id_o      = id_q;
  assign b_resp_o    = b_resp_q;
  assign b_valid_o   = b_valid_q;
  assign r_id_o      = id_q;
  assign r_data_o    = r_data_q;
  assign r_resp_o    = r_resp_q;
  assign r_last_o    = r_last_q;
  assign r_valid_o   = r_valid_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_wstrb_o = reg_wstrb_q;
  assign reg_write_o = reg_write_q;
  assign reg_valid_o = reg_valid_q;

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Self-checking bench for axi_reg_bridge: directed cases followed by random
// transactions, each checked against a transaction-level reference model.
module tb_axi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [63:0] w_data, r_data;
  logic [7:0]  w_strb;
  logic        w_last, w_valid, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic        b_valid, b_ready, r_last, r_valid, r_ready;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;
  logic        reg_write, reg_valid, reg_ready, reg_error;

  always #5 clk = ~clk;

  axi_reg_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
    .reg_write_o(reg_write), .reg_valid_o(reg_valid), .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error)
  );

  typedef struct {
    logic [6:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          reg_dly;
    int          resp_dly;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;
  bit prio_write = 1'b1;   // model of the tie-break priority

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_legal(input txn_t t);
    return (t.len == 8'd0) && (t.size <= 3'd2);
  endfunction

  function automatic logic [7:0] exp_addr(input txn_t t);
    return t.addr[7:0] & 8'hFC;
  endfunction

  function automatic logic [31:0] exp_wdata(input txn_t t);
    return t.addr[2] ? t.wdata[63:32] : t.wdata[31:0];
  endfunction

  function automatic logic [3:0] exp_wstrb(input txn_t t);
    logic [7:0] s;
    s = t.addr[2] ? (t.strb >> 4) : t.strb;
    return s[3:0];
  endfunction

  function automatic logic [1:0] exp_resp(input txn_t t);
    if (!is_legal(t)) return 2'b10;
    return t.err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [63:0] exp_rdata(input txn_t t);
    if (!is_legal(t)) return 64'd0;
    return {t.rdata, t.rdata};
  endfunction

  function automatic txn_t mk(input logic [6:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [63:0] wdata, input logic [7:0] strb,
                              input logic [31:0] rdata, input logic err,
                              input int reg_dly, input int resp_dly);
    txn_t t;
    t.id = id; t.addr = addr; t.len = len; t.size = size; t.wdata = wdata;
    t.strb = strb; t.rdata = rdata; t.err = err; t.reg_dly = reg_dly; t.resp_dly = resp_dly;
    return t;
  endfunction

  function automatic txn_t gen_txn();
    txn_t t;
    t = mk(7'($urandom_range(0, 127)), $urandom, 8'd0, 3'($urandom_range(0, 2)),
           {$urandom, $urandom}, 8'($urandom_range(0, 255)), $urandom,
           ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
    if ($urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 0) t.len = 8'($urandom_range(1, 3));
      else begin t.size = 3'($urandom_range(3, 7)); t.len = 8'($urandom_range(0, 2)); end
    end
    return t;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_aw_ready"}, aw_ready, 1'b0);
    check({tag, "_ar_ready"}, ar_ready, 1'b0);
    check({tag, "_w_ready"}, w_ready, 1'b0);
    check({tag, "_b_valid"}, b_valid, 1'b0);
    check({tag, "_b_id_resp"}, {b_id, b_resp}, 9'd0);
    check({tag, "_r_valid"}, r_valid, 1'b0);
    check({tag, "_r_fields"}, {r_id, r_resp, r_last}, 10'd0);
    check({tag, "_r_data"}, r_data, 64'd0);
    check({tag, "_reg_valid"}, reg_valid, 1'b0);
    check({tag, "_reg_fields"}, {reg_addr, reg_wstrb, reg_write}, 13'd0);
    check({tag, "_reg_wdata"}, reg_wdata, 32'd0);
  endtask

  task automatic check_wreq(input txn_t t);
    check("wreq_valid", reg_valid, 1'b1);
    check("wreq_write", reg_write, 1'b1);
    check("wreq_addr", reg_addr, exp_addr(t));
    check("wreq_wdata", reg_wdata, exp_wdata(t));
    check("wreq_wstrb", reg_wstrb, exp_wstrb(t));
  endtask

  task automatic drive_aw(input txn_t t);
    aw_id = t.id; aw_addr = t.addr; aw_len = t.len; aw_size = t.size; aw_valid = 1'b1;
    w_data = t.wdata; w_strb = t.strb; w_last = (t.len == 8'd0); w_valid = 1'b1;
  endtask

  task automatic drive_ar(input txn_t t);
    ar_id = t.id; ar_addr = t.addr; ar_len = t.len; ar_size = t.size; ar_valid = 1'b1;
  endtask

  // Entered and left just after a rising edge.
  task automatic run_write(input txn_t t);
    bit legal;
    bit reg_seen;
    int n;
    legal = is_legal(t);
    drive_aw(t);
    @(negedge clk);
    check("aw_ready", aw_ready, 1'b1);
    check("ar_ready_blocked", ar_ready, 1'b0);
    check("w_ready_before_aw", w_ready, 1'b0);
    check("idle_no_resp", {b_valid, r_valid}, 2'b00);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int b = 0; b <= int'(t.len); b++) begin
      if (b > 0) begin w_data = {$urandom, $urandom}; w_strb = 8'($urandom); end
      w_last = (b == int'(t.len));
      @(negedge clk);
      check("w_ready", w_ready, 1'b1);
      check("reg_quiet_wdata", reg_valid, 1'b0);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    if (legal) begin
      reg_ready = (t.reg_dly == 0); reg_error = t.err; reg_rdata = $urandom;
      @(negedge clk);
      check_wreq(t);
      check("b_early", b_valid, 1'b0);
      for (int d = 1; d <= t.reg_dly; d++) begin
        @(posedge clk); #1;
        if (d == t.reg_dly) reg_ready = 1'b1;
        @(negedge clk);
        check_wreq(t);
      end
      @(posedge clk); #1;
      reg_ready = 1'b0; reg_error = 1'b0;
      @(negedge clk);
    end else begin
      reg_ready = 1'b1; reg_error = 1'b0; n = 0;
      @(negedge clk);
      reg_seen = reg_valid;
      while (!b_valid && n < 8) begin
        @(posedge clk); @(negedge clk);
        reg_seen |= reg_valid; n++;
      end
      check("err_write_no_reg", reg_seen, 1'b0);
      reg_ready = 1'b0;
    end
    check("b_valid", b_valid, 1'b1);
    check("b_id", b_id, t.id);
    check("b_resp", b_resp, exp_resp(t));
    check("reg_idle_at_b", reg_valid, 1'b0);
    for (int d = 0; d < t.resp_dly; d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("b_stall_valid", b_valid, 1'b1);
      check("b_stall_fields", {b_id, b_resp}, {t.id, exp_resp(t)});
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  // Entered and left just after a rising edge.
  task automatic run_read(input txn_t t);
    bit legal;
    bit reg_seen;
    int n;
    legal = is_legal(t);
    reg_seen = 1'b0;
    drive_ar(t);
    reg_ready = legal ? (t.reg_dly == 0) : 1'b1;
    reg_rdata = t.rdata; reg_error = t.err;
    @(negedge clk);
    check("ar_ready", ar_ready, 1'b1);
    check("aw_ready_blocked", aw_ready, 1'b0);
    check("w_ready_in_read", w_ready, 1'b0);
    check("idle_no_resp", {b_valid, r_valid}, 2'b00);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    if (legal) begin
      @(negedge clk);
      check("rreq_valid", reg_valid, 1'b1);
      check("rreq_write", reg_write, 1'b0);
      check("rreq_addr", reg_addr, exp_addr(t));
      check("r_early", r_valid, 1'b0);
      for (int d = 1; d <= t.reg_dly; d++) begin
        @(posedge clk); #1;
        if (d == t.reg_dly) reg_ready = 1'b1;
        @(negedge clk);
        check("rreq_stall", {reg_valid, reg_write, reg_addr}, {1'b1, 1'b0, exp_addr(t)});
      end
      @(posedge clk); #1;
      // Scramble the bus so only the latched value can satisfy the check.
      reg_ready = 1'b0; reg_rdata = ~t.rdata; reg_error = ~t.err;
    end
    for (int b = 0; b <= int'(t.len); b++) begin
      n = 0;
      @(negedge clk);
      reg_seen |= reg_valid;
      while (!r_valid && !legal && n < 8) begin
        @(posedge clk); @(negedge clk);
        reg_seen |= reg_valid; n++;
      end
      check("r_valid", r_valid, 1'b1);
      check("r_id", r_id, t.id);
      check("r_data", r_data, exp_rdata(t));
      check("r_resp_last", {r_resp, r_last}, {exp_resp(t), (b == int'(t.len))});
      for (int d = 0; d < t.resp_dly; d++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("r_stall", {r_valid, r_id, r_resp, r_last}, {1'b1, t.id, exp_resp(t), (b == int'(t.len))});
        check("r_stall_data", r_data, exp_rdata(t));
      end
      r_ready = 1'b1;
      @(posedge clk); #1;
      r_ready = 1'b0;
    end
    check("rd_reg_quiet", reg_seen, 1'b0);
    reg_ready = 1'b0; reg_error = 1'b0;
  endtask

  // Both requests presented together; the model's priority picks the winner.
  task automatic run_both(input txn_t tw, input txn_t tr);
    bit write_first;
    write_first = prio_write;
    prio_write = !prio_write;
    if (write_first) begin
      drive_ar(tr);
      run_write(tw);
      run_read(tr);
    end else begin
      drive_aw(tw);
      run_read(tr);
      run_write(tw);
    end
  endtask

  task automatic reset_in_wreq();
    txn_t t;
    t = mk(7'd17, 32'h0000_0020, 8'd0, 3'd2, 64'h1111_2222_3333_4444, 8'hFF, 32'd0, 1'b0, 0, 0);
    drive_aw(t);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; reg_ready = 1'b0;
    @(negedge clk);
    check("rst_pre_wreq", reg_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_resp", {b_valid, reg_valid, r_valid}, 3'b000);
    end
    prio_write = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    txn_t t, t2;
    rst = 1'b1;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; r_ready = 1'b0;
    reg_ready = 1'b0; reg_rdata = '0; reg_error = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    run_write(mk(7'd5, 32'h0100_00D0, 8'd0, 3'd2, 64'h0000_0000_8000_0100, 8'h0F, 32'd0, 1'b0, 0, 0));
    run_write(mk(7'd9, 32'h0000_0044, 8'd0, 3'd2, 64'hDEAD_BEEF_1234_5678, 8'hF0, 32'd0, 1'b0, 0, 0));
    run_read(mk(7'd3, 32'h0100_0048, 8'd0, 3'd2, 64'd0, 8'd0, 32'd3, 1'b0, 0, 0));
    run_read(mk(7'd44, 32'h0000_0010, 8'd0, 3'd2, 64'd0, 8'd0, 32'hCAFE_F00D, 1'b1, 2, 2));
    run_write(mk(7'd6, 32'h0000_0008, 8'd3, 3'd2, 64'h0123_4567_89AB_CDEF, 8'hFF, 32'd0, 1'b0, 0, 1));
    run_write(mk(7'd7, 32'h0000_000C, 8'd0, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 32'd0, 1'b0, 0, 0));
    run_read(mk(7'd8, 32'h0000_00F0, 8'd2, 3'd2, 64'd0, 8'd0, 32'h5555_AAAA, 1'b0, 0, 1));
    run_write(mk(7'd10, 32'hFFFF_FF7C, 8'd0, 3'd1, 64'hAAAA_5555_0F0F_F0F0, 8'h30, 32'd0, 1'b1, 10, 3));
    run_write(mk(7'd11, 32'h0000_0004, 8'd0, 3'd2, 64'h7777_6666_5555_4444, 8'h00, 32'd0, 1'b0, 1, 0));
    reset_in_wreq();
    t  = mk(7'd20, 32'h0000_0030, 8'd0, 3'd2, 64'h0BAD_F00D_0000_0001, 8'h0F, 32'd0, 1'b0, 0, 0);
    t2 = mk(7'd21, 32'h0000_0034, 8'd0, 3'd2, 64'd0, 8'd0, 32'h1234_5678, 1'b0, 0, 0);
    run_both(t, t2);
    run_both(t, t2);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      t  = gen_txn();
      t2 = gen_txn();
      case ($urandom_range(0, 2))
        0: run_write(t);
        1: run_read(t2);
        default: run_both(t, t2);
      endcase
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
